// File: rtl/jt053260_kadpcm_pkg.sv
// rtl/jt053260_kadpcm_pkg.sv - KADPCM shared types and code-to-delta table
package jt053260_kadpcm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRCH,
        ST_COMMIT,
        ST_OUT
    } kadpcm_st_t;

    localparam logic [8:0] ERR_MAX = 9'h1ff;

    // Single source of the delta table for both encoder and decoder
    function automatic logic signed [7:0] kadpcm_delta(input logic [3:0] code);
        case (code)
            4'h0: kadpcm_delta = 8'sd0;
            4'h1: kadpcm_delta = 8'sd1;
            4'h2: kadpcm_delta = 8'sd2;
            4'h3: kadpcm_delta = 8'sd4;
            4'h4: kadpcm_delta = 8'sd8;
            4'h5: kadpcm_delta = 8'sd16;
            4'h6: kadpcm_delta = 8'sd32;
            4'h7: kadpcm_delta = 8'sd64;
            4'h8: kadpcm_delta = -8'sd128;
            4'h9: kadpcm_delta = -8'sd64;
            4'ha: kadpcm_delta = -8'sd32;
            4'hb: kadpcm_delta = -8'sd16;
            4'hc: kadpcm_delta = -8'sd8;
            4'hd: kadpcm_delta = -8'sd4;
            4'he: kadpcm_delta = -8'sd2;
            default: kadpcm_delta = -8'sd1;
        endcase
    endfunction

endpackage

// File: rtl/jt053260_kadpcm_lut.sv
// rtl/jt053260_kadpcm_lut.sv - combinational KADPCM code to signed delta
module jt053260_kadpcm_lut
    import jt053260_kadpcm_pkg::*;
(
    input  logic        [3:0] code,
    output logic signed [7:0] delta
);

    assign delta = kadpcm_delta(code);

endmodule

// File: rtl/jt053260_kadpcm_enc.sv
// rtl/jt053260_kadpcm_enc.sv - KADPCM encoder, exhaustive code search, two codes per byte
module jt053260_kadpcm_enc
    import jt053260_kadpcm_pkg::*;
#(
    parameter int SRCH_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       clr,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic [7:0] i_pcm,
    input  logic       i_last,
    output logic       o_valid,
    input  logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_last
);

    localparam logic [3:0] LAST_K = 4'(SRCH_CYC - 1);

    kadpcm_st_t        st;
    logic signed [7:0] acc;
    logic signed [7:0] tgt;
    logic              lst;
    logic              phase;
    logic        [3:0] k;
    logic        [3:0] best;
    logic        [3:0] nib_lo;
    logic        [8:0] best_err;

    logic        [3:0] lut_code;
    logic signed [7:0] delta;
    logic signed [8:0] cand;
    logic signed [9:0] diff;
    logic        [8:0] err;
    logic              cand_ok;

    // One LUT serves both the search (code k) and the commit (winning code)
    assign lut_code = (st == ST_COMMIT) ? best : k;

    jt053260_kadpcm_lut u_lut (
        .code  (lut_code),
        .delta (delta)
    );

    assign cand    = {acc[7], acc} + {delta[7], delta};
    assign cand_ok = (cand[8] == cand[7]);
    assign diff    = {{2{tgt[7]}}, tgt} - {cand[8], cand};
    assign err     = diff[9] ? 9'(-diff) : diff[8:0];

    assign i_ready = ~rst & (st == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            acc      <= '0;
            tgt      <= '0;
            lst      <= 1'b0;
            phase    <= 1'b0;
            k        <= '0;
            best     <= '0;
            best_err <= ERR_MAX;
            nib_lo   <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
        end else if (cen) begin
            if (clr) begin
                st      <= ST_IDLE;
                acc     <= '0;
                phase   <= 1'b0;
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (i_valid) begin
                            tgt      <= i_pcm;
                            lst      <= i_last;
                            k        <= '0;
                            best     <= '0;
                            best_err <= ERR_MAX;
                            st       <= ST_SRCH;
                        end
                    end
                    ST_SRCH: begin
                        // Strict compare keeps the lower code on ties
                        if (cand_ok && (err < best_err)) begin
                            best     <= k;
                            best_err <= err;
                        end
                        k <= k + 4'd1;
                        if (k == LAST_K) st <= ST_COMMIT;
                    end
                    ST_COMMIT: begin
                        acc <= acc + delta;
                        if (!phase) begin
                            nib_lo <= best;
                            if (lst) begin
                                o_data  <= {4'h0, best};
                                o_last  <= 1'b1;
                                o_valid <= 1'b1;
                                st      <= ST_OUT;
                            end else begin
                                phase <= 1'b1;
                                st    <= ST_IDLE;
                            end
                        end else begin
                            o_data  <= {best, nib_lo};
                            o_last  <= lst;
                            o_valid <= 1'b1;
                            st      <= ST_OUT;
                        end
                    end
                    ST_OUT: begin
                        if (o_ready) begin
                            o_valid <= 1'b0;
                            phase   <= 1'b0;
                            st      <= ST_IDLE;
                            if (o_last) acc <= '0;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt053260_kadpcm_enc.sv
// tb/tb_jt053260_kadpcm_enc.sv - self-checking bench for the KADPCM encoder
module tb_jt053260_kadpcm_enc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       clr = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_last = 1'b0;
    logic [7:0] i_pcm = 8'h00;
    logic       o_ready = 1'b1;
    logic       i_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;

    int errors = 0;
    int checks = 0;

    jt053260_kadpcm_enc #(.SRCH_CYC(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .clr     (clr),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_pcm   (i_pcm),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: codes chosen from the delta rule by plain arithmetic
    typedef struct {
        logic [7:0] d;
        logic       l;
    } byte_t;

    byte_t expq[$];
    int    macc   = 0;
    int    mphase = 0;
    int    mnib   = 0;

    function automatic int mdelta(input int c);
        if (c == 0) return 0;
        if (c < 8) return 1 << (c - 1);
        return -(1 << (15 - c));
    endfunction

    function automatic int best_code(input int acc, input int tgt);
        int be = 100000;
        int bc = 0;
        for (int c = 0; c < 16; c++) begin
            int cv = acc + mdelta(c);
            int e;
            if (cv < -128 || cv > 127) continue;
            e = tgt - cv;
            if (e < 0) e = -e;
            if (e < be) begin
                be = e;
                bc = c;
            end
        end
        return bc;
    endfunction

    task automatic model_push(input int pcm, input bit last);
        int    c;
        byte_t b;
        c = best_code(macc, pcm);
        macc += mdelta(c);
        if (mphase == 0) begin
            mnib = c;
            if (last) begin
                b.d = {4'h0, 4'(c)};
                b.l = 1'b1;
                expq.push_back(b);
                macc = 0;
            end else begin
                mphase = 1;
            end
        end else begin
            b.d = {4'(c), 4'(mnib)};
            b.l = last;
            expq.push_back(b);
            mphase = 0;
            if (last) macc = 0;
        end
    endtask

    task automatic model_clr();
        macc   = 0;
        mphase = 0;
        expq.delete();
    endtask

    // Compare process: every accepted byte against the model, holds under backpressure
    logic [7:0] prev_d = 8'h00;
    logic       prev_v = 1'b0;
    logic [7:0] last_byte = 8'h00;
    logic       last_l = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                chk("i_ready_in_out", i_ready, 0);
                if (prev_v) begin
                    chk("hold_data", o_data, prev_d);
                    chk("hold_last", o_last, last_l);
                end
                if (o_ready && cen && !clr) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_byte", o_data, 32'hdead);
                    end else begin
                        byte_t b;
                        b = expq.pop_front();
                        chk("byte_data", o_data, b.d);
                        chk("byte_last", o_last, b.l);
                    end
                    last_byte = o_data;
                end
                last_l = o_last;
            end
            prev_v = o_valid && !(o_ready && cen && !clr);
            prev_d = o_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int pcm, input bit last);
        int t = 0;
        while (!i_ready && t < 200) begin
            tick(1);
            t++;
        end
        if (t >= 200) chk("send_timeout", 1, 0);
        i_pcm   = pcm[7:0];
        i_last  = last;
        i_valid = 1'b1;
        model_push(pcm, last);
        @(posedge clk);
        #2;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        tick(1);
        while (!(i_ready && !o_valid) && t < 200) begin
            tick(1);
            t++;
        end
        if (t >= 200) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Model pins
        chk("model_0_to_1", best_code(0, 1), 1);
        chk("model_1_to_3", best_code(1, 3), 2);
        chk("model_64_to_127", best_code(64, 127), 6);
        chk("model_0_to_m128", best_code(0, -128), 8);
        chk("model_tie_0_to_3", best_code(0, 3), 2);

        // 1: reset
        tick(3);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_i_ready", i_ready, 1);
        chk("post_rst_o_valid", o_valid, 0);
        chk("post_rst_o_data", o_data, 8'h00);
        chk("post_rst_o_last", o_last, 0);
        tick(2);

        // 2: 1 then 3, with latency
        send(1, 0);
        send(3, 0);
        tick(16);
        chk("lat_not_yet", o_valid, 0);
        chk("lat_busy_i_ready", i_ready, 0);
        tick(1);
        chk("lat_valid", o_valid, 1);
        chk("lat_data", o_data, 8'h21);
        wait_idle();
        chk("byte_21", last_byte, 8'h21);

        // 3: overflow skip
        send(127, 0);
        send(127, 0);
        wait_idle();
        chk("byte_67", last_byte, 8'h67);

        clr = 1'b1;
        model_clr();
        tick(1);
        clr = 1'b0;

        // 4: single last sample, then acc back at zero
        send(-128, 1);
        wait_idle();
        chk("byte_08", last_byte, 8'h08);
        chk("byte_08_last", last_l, 1);
        send(1, 1);
        wait_idle();
        chk("byte_01_acc0", last_byte, 8'h01);

        // 5: tie goes to lower code, acc then 2
        send(3, 0);
        send(2, 1);
        wait_idle();
        chk("byte_tie_02", last_byte, 8'h02);

        // 6a: backpressure and cen freeze
        o_ready = 1'b0;
        send(5, 0);
        send(-7, 1);
        begin
            int t = 0;
            while (!o_valid && t < 100) begin
                tick(1);
                t++;
            end
            if (t >= 100) chk("bp_timeout", 1, 0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_valid", o_valid, 1);
            chk("bp_data", o_data, 8'hc3);
            chk("bp_i_ready", i_ready, 0);
        end
        cen = 1'b0;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("cen0_valid", o_valid, 1);
        end
        cen = 1'b1;
        wait_idle();
        chk("byte_c3", last_byte, 8'hc3);
        chk("byte_c3_last", last_l, 1);

        // 6b: clr mid-search drops the pending byte
        send(1, 0);
        send(50, 0);
        tick(5);
        clr = 1'b1;
        model_clr();
        tick(1);
        clr = 1'b0;
        chk("clr_o_valid", o_valid, 0);
        chk("clr_i_ready", i_ready, 1);
        tick(25);
        chk("clr_no_byte", o_valid, 0);
        send(2, 0);
        send(4, 1);
        wait_idle();
        chk("byte_after_clr_22", last_byte, 8'h22);

        tick(2);
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
